// File: rtl/voice_mixer.sv
// voice_mixer: per-voice attack/release envelope and saturating mix, one voice per clock.
// Revision: 1.0
`default_nettype none

module voice_mixer #(
  parameter int NUM_VOICES   = 8,
  parameter int SAMPLE_WIDTH = 8,
  parameter int OUT_WIDTH    = 8,
  parameter int ATTACK_STEP  = 8,
  parameter int RELEASE_STEP = 4
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               sample_valid_in,
  input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] sample_in,
  input  logic [NUM_VOICES-1:0]              gate_in,
  output logic [OUT_WIDTH-1:0]               dc_out,
  output logic                               dc_valid_out,
  output logic [NUM_VOICES-1:0]              active_out,
  output logic                               busy_out,
  output logic                               overrun_out
);

  localparam int ACC_W  = SAMPLE_WIDTH + $clog2(NUM_VOICES) + 1;
  localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int PROD_W = SAMPLE_WIDTH + 8;
  localparam logic [63:0] DC_MAX = (64'd1 << OUT_WIDTH) - 64'd1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_OUTPUT = 2'd2
  } state_t;

  state_t                             state_q, state_d;
  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] frame_sample_q, frame_sample_d;
  logic [NUM_VOICES-1:0]              frame_gate_q, frame_gate_d;
  logic [7:0]                         env_q [NUM_VOICES];
  logic [7:0]                         env_d [NUM_VOICES];
  logic [ACC_W-1:0]                   acc_q, acc_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [OUT_WIDTH-1:0]               dc_q, dc_d;
  logic                               dc_valid_q, dc_valid_d;
  logic [NUM_VOICES-1:0]              active_q, active_d;
  logic                               busy_q, busy_d;
  logic                               overrun_q, overrun_d;

  logic [SAMPLE_WIDTH-1:0] cur_sample;
  logic                    cur_gate;
  logic [7:0]              cur_env;
  logic [8:0]              attack_sum;
  logic [7:0]              env_n;
  logic [PROD_W-1:0]       prod;
  logic [ACC_W-1:0]        acc_next;

  always_comb begin
    cur_sample = frame_sample_q[idx_q*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    cur_gate   = frame_gate_q[idx_q];
    cur_env    = env_q[idx_q];
    attack_sum = {1'b0, cur_env} + 9'(ATTACK_STEP);
    // Envelope clamps at both ends instead of wrapping.
    if (cur_gate) begin
      env_n = attack_sum[8] ? 8'hFF : attack_sum[7:0];
    end else if (cur_env >= 8'(RELEASE_STEP)) begin
      env_n = cur_env - 8'(RELEASE_STEP);
    end else begin
      env_n = 8'd0;
    end
    prod     = PROD_W'(cur_sample) * PROD_W'(env_n);
    acc_next = acc_q + ACC_W'(prod >> 8);
  end

  always_comb begin
    state_d        = state_q;
    frame_sample_d = frame_sample_q;
    frame_gate_d   = frame_gate_q;
    env_d          = env_q;
    acc_d          = acc_q;
    idx_d          = idx_q;
    dc_d           = dc_q;
    dc_valid_d     = 1'b0;
    active_d       = active_q;
    busy_d         = busy_q;
    overrun_d      = overrun_q;
    case (state_q)
      S_IDLE: begin
        if (sample_valid_in) begin
          frame_sample_d = sample_in;
          frame_gate_d   = gate_in;
          acc_d          = '0;
          idx_d          = '0;
          busy_d         = 1'b1;
          state_d        = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (sample_valid_in) overrun_d = 1'b1;
        env_d[idx_q]    = env_n;
        acc_d           = acc_next;
        active_d[idx_q] = cur_gate | (env_n != 8'd0);
        idx_d           = idx_q + IDX_W'(1);
        // Result is registered on the last voice so it is visible during OUTPUT.
        if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
          dc_d       = (64'(acc_next) > DC_MAX) ? OUT_WIDTH'(DC_MAX) : OUT_WIDTH'(acc_next);
          dc_valid_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (sample_valid_in) overrun_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= S_IDLE;
      frame_sample_q <= '0;
      frame_gate_q   <= '0;
      for (int i = 0; i < NUM_VOICES; i++) env_q[i] <= 8'd0;
      acc_q          <= '0;
      idx_q          <= '0;
      dc_q           <= '0;
      dc_valid_q     <= 1'b0;
      active_q       <= '0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_sample_q <= frame_sample_d;
      frame_gate_q   <= frame_gate_d;
      for (int i = 0; i < NUM_VOICES; i++) env_q[i] <= env_d[i];
      acc_q          <= acc_d;
      idx_q          <= idx_d;
      dc_q           <= dc_d;
      dc_valid_q     <= dc_valid_d;
      active_q       <= active_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
    end
  end

  assign dc_out       = dc_q;
  assign dc_valid_out = dc_valid_q;
  assign active_out   = active_q;
  assign busy_out     = busy_q;
  assign overrun_out  = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: directed and random frames checked against a frame-level envelope/mix model.
// Revision: 1.0
`default_nettype none

module tb_voice_mixer;

  localparam int NV  = 8;
  localparam int SW  = 8;
  localparam int OW  = 8;
  localparam int ATK = 64;
  localparam int REL = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid;
  logic [NV*SW-1:0] sample;
  logic [NV-1:0]    gate;
  logic [OW-1:0]    dc_out;
  logic             dc_valid_out;
  logic [NV-1:0]    active_out;
  logic             busy_out;
  logic             overrun_out;

  voice_mixer #(
    .NUM_VOICES  (NV),
    .SAMPLE_WIDTH(SW),
    .OUT_WIDTH   (OW),
    .ATTACK_STEP (ATK),
    .RELEASE_STEP(REL)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .sample_valid_in(valid),
    .sample_in      (sample),
    .gate_in        (gate),
    .dc_out         (dc_out),
    .dc_valid_out   (dc_valid_out),
    .active_out     (active_out),
    .busy_out       (busy_out),
    .overrun_out    (overrun_out)
  );

  always #5 clk = ~clk;

  int            tests = 0;
  int            fails = 0;
  int            env_m [NV];
  logic [NV-1:0] active_m;
  logic          overrun_m;
  int            dc_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: one whole frame of envelope steps and a clamped mix, in plain integers.
  function automatic void model_frame(input logic [NV*SW-1:0] s, input logic [NV-1:0] g);
    int acc = 0;
    for (int i = 0; i < NV; i++) begin
      if (g[i]) env_m[i] = (env_m[i] + ATK > 255) ? 255 : env_m[i] + ATK;
      else      env_m[i] = (env_m[i] - REL < 0)   ? 0   : env_m[i] - REL;
      acc += (int'(s[i*SW +: SW]) * env_m[i]) / 256;
      active_m[i] = g[i] || (env_m[i] != 0);
    end
    dc_m = (acc > 255) ? 255 : acc;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) env_m[i] = 0;
    active_m  = '0;
    overrun_m = 1'b0;
  endfunction

  task automatic wait_pulse(inout int n);
    while (dc_valid_out !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (dc_valid_out === 1'b1) pulses++;
    end
  endtask

  task automatic run_frame(input logic [NV*SW-1:0] s, input logic [NV-1:0] g);
    int n;
    @(negedge clk);
    check("pulse_single_cycle", 64'(dc_valid_out), 64'd0);
    sample = s;
    gate   = g;
    valid  = 1'b1;
    @(negedge clk);
    valid  = 1'b0;
    gate   = ~g;
    sample = {$urandom, $urandom};
    check("busy_during_accum", 64'(busy_out), 64'd1);
    n = 1;
    wait_pulse(n);
    model_frame(s, g);
    check("latency", 64'(n), 64'(NV + 1));
    check("dc_out", 64'(dc_out), 64'(dc_m));
    check("active_out", 64'(active_out), 64'(active_m));
    check("busy_at_output", 64'(busy_out), 64'd0);
    check("overrun_out", 64'(overrun_out), 64'(overrun_m));
  endtask

  initial begin
    int t1_exp [4];
    int n;
    int pulses;
    logic [NV*SW-1:0] s4;
    logic [NV-1:0]    g4;
    t1_exp = '{50, 100, 150, 199};

    rst    = 1'b1;
    valid  = 1'b0;
    sample = '0;
    gate   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_dc_out", 64'(dc_out), 64'd0);
    check("reset_dc_valid", 64'(dc_valid_out), 64'd0);
    check("reset_active", 64'(active_out), 64'd0);
    check("reset_busy", 64'(busy_out), 64'd0);
    check("reset_overrun", 64'(overrun_out), 64'd0);
    rst = 1'b0;

    // Attack ramp on voice 0.
    for (int k = 0; k < 4; k++) begin
      run_frame(64'd200, 8'h01);
      check("t1_level", 64'(dc_out), 64'(t1_exp[k]));
    end

    // Release ramp on voice 0.
    run_frame(64'd200, 8'h00);
    check("t2_first_release", 64'(dc_out), 64'd186);
    for (int r = 2; r <= 16; r++) begin
      run_frame(64'd200, 8'h00);
      check("t2_active0", 64'(active_out[0]), (r < 16) ? 64'd1 : 64'd0);
    end

    // All voices full scale until saturated.
    for (int k = 0; k < 5; k++) run_frame({NV{8'd255}}, 8'hFF);
    check("t3_saturated", 64'(dc_out), 64'd255);

    // Second strobe 3 cycles into a frame is dropped and flags overrun.
    s4 = {$urandom, $urandom};
    g4 = 8'($urandom);
    @(negedge clk);
    sample = s4; gate = g4; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sample = ~s4; gate = ~g4; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    overrun_m = 1'b1;
    check("t4_overrun_set", 64'(overrun_out), 64'd1);
    n = 4;
    wait_pulse(n);
    model_frame(s4, g4);
    check("t4_latency", 64'(n), 64'(NV + 1));
    check("t4_dc_out", 64'(dc_out), 64'(dc_m));
    check("t4_active", 64'(active_out), 64'(active_m));
    count_pulses(12, pulses);
    check("t4_single_pulse", 64'(pulses), 64'd0);
    check("t4_overrun_sticky", 64'(overrun_out), 64'd1);

    // Reset mid-accumulation discards the frame.
    @(negedge clk);
    sample = {NV{8'd255}}; gate = 8'hFF; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("t5_dc_out", 64'(dc_out), 64'd0);
    check("t5_active", 64'(active_out), 64'd0);
    check("t5_busy", 64'(busy_out), 64'd0);
    check("t5_overrun", 64'(overrun_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    count_pulses(12, pulses);
    check("t5_no_pulse", 64'(pulses), 64'd0);

    // Back-to-back random frames at full throughput.
    for (int k = 0; k < 100; k++) run_frame({$urandom, $urandom}, 8'($urandom));
    check("t6_no_overrun", 64'(overrun_out), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
